// File: rtl/rv32m_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32m_pkg                                                    |
// | Description : Shared RV32M constants: funct3 codes, divider FSM states and |
// |               architecturally defined special divide results.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rv32m_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;

endpackage : rv32m_pkg
`default_nettype wire

// File: rtl/rv32m_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32m_div_unit                                               |
// | Description : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU,   |
// |               stalling the pipeline through o_busy while in flight.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32m_div_unit
    import rv32m_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_kill,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic [4:0]       i_rd_in,
    output logic [WIDTH-1:0] o_result,
    output logic [4:0]       o_rd_out,
    output logic             o_done,
    output logic             o_busy
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rd;
    logic             r_done;
    logic             r_sel_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_idle_or_done;
    logic             w_accept;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [1:0]       w_unused;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept       = i_start && w_idle_or_done;
    assign w_signed       = ~i_funct3[0];

    assign w_abs_a = (w_signed && i_operand_a[WIDTH-1]) ? -i_operand_a : i_operand_a;
    assign w_abs_b = (w_signed && i_operand_b[WIDTH-1]) ? -i_operand_b : i_operand_b;

    assign w_div_zero = (i_operand_b == '0);
    assign w_overflow = w_signed && (i_operand_a == C_INT_MIN) && (i_operand_b == C_ALL_ONES);

    // Dividend bits leave the top of r_quot and enter the partial remainder.
    assign w_shift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = w_shift - {1'b0, r_divisor};

    assign w_quot_fix = r_neg_q ? -r_quot : r_quot;
    assign w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // The remainder MSB is always cleared after a restoring step.
    assign w_unused = {i_funct3[2], r_rem[WIDTH]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_rd      <= '0;
            r_done    <= 1'b0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (i_kill) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_rd      <= i_rd_in;
                        r_sel_rem <= i_funct3[1];
                        r_neg_q   <= w_signed && (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]);
                        r_neg_r   <= w_signed && i_operand_a[WIDTH-1];
                        r_quot    <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_rem     <= '0;
                        if (w_div_zero) begin
                            r_result <= i_funct3[1] ? i_operand_a : C_ALL_ONES;
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                        end else if (w_overflow) begin
                            r_result <= i_funct3[1] ? '0 : C_INT_MIN;
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            r_state <= ST_CALC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rem  <= w_ge ? w_diff : w_shift;
                    r_quot <= {r_quot[WIDTH-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    r_result <= r_sel_rem ? w_rem_fix : w_quot_fix;
                    r_state  <= ST_DONE;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = (i_start && w_idle_or_done && !i_kill)
                    || (r_state == ST_CALC) || (r_state == ST_FIX);
    assign o_result = r_result;
    assign o_rd_out = r_rd;
    assign o_done   = r_done;

endmodule : rv32m_div_unit
`default_nettype wire
